// File: rtl/tt_um_oscarrp1091.sv
// 8-bit accumulator ALU in the TinyTapeout user-project wrapper.
// Latency: result and flags appear on outputs right after the executing clk edge (1 cycle).
// Backpressure: none; an op fires once per low->high strobe edge while ena=1, otherwise state holds.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   ena         - enable; when low, accumulator, flags and strobe history freeze
//   ui_in       - operand B
//   uio_in      - [2:0] opcode, [3] execute strobe, [7:4] ignored
//   uo_out      - accumulator A
//   uio_out     - [7] Z, [6] C, [5] N, [4] V, [3:0] zero
//   uio_oe      - constant 8'hF0 (upper nibble driven, lower nibble input)
module tt_um_oscarrp1091 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_ADC  = 3'd7
  } op_e;

  logic [7:0] acc;
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;
  logic       flag_v;
  logic       stb_q;

  op_e        op;
  logic [7:0] opb;
  logic       stb;
  logic       fire;
  logic       carry_in;
  logic [8:0] add9;
  logic [8:0] sub9;
  logic [7:0] res;
  logic       res_c;
  logic       res_v;

  // Upper nibble of uio_in carries nothing for this block.
  logic       unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:4]};

  assign op  = op_e'(uio_in[2:0]);
  assign opb = ui_in;
  assign stb = uio_in[3];

  // Fire only on the enabled cycle where the strobe is seen rising.
  assign fire = ena & stb & ~stb_q;

  // ADD and ADC share one adder; only ADC feeds the old carry in.
  assign carry_in = (op == OP_ADC) ? flag_c : 1'b0;
  assign add9     = {1'b0, acc} + {1'b0, opb} + {8'd0, carry_in};
  // Bit 8 of the 9-bit difference is the borrow (set iff acc < opb).
  assign sub9     = {1'b0, acc} - {1'b0, opb};

  always_comb begin
    res   = acc;
    res_c = flag_c;
    res_v = flag_v;
    case (op)
      OP_LOAD: begin
        res   = opb;
        res_c = 1'b0;
        res_v = 1'b0;
      end
      OP_ADD, OP_ADC: begin
        res   = add9[7:0];
        res_c = add9[8];
        res_v = (acc[7] == opb[7]) && (add9[7] != acc[7]);
      end
      OP_SUB: begin
        res   = sub9[7:0];
        res_c = sub9[8];
        res_v = (acc[7] != opb[7]) && (sub9[7] != acc[7]);
      end
      OP_AND: begin
        res   = acc & opb;
        res_c = 1'b0;
        res_v = 1'b0;
      end
      OP_OR: begin
        res   = acc | opb;
        res_c = 1'b0;
        res_v = 1'b0;
      end
      OP_XOR: begin
        res   = acc ^ opb;
        res_c = 1'b0;
        res_v = 1'b0;
      end
      OP_SHL: begin
        res   = {acc[6:0], 1'b0};
        res_c = acc[7];
        res_v = 1'b0;
      end
      default: begin
        res   = acc;
        res_c = flag_c;
        res_v = flag_v;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= 8'h00;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      stb_q  <= 1'b0;
    end else if (ena) begin
      stb_q <= stb;
      if (fire) begin
        acc    <= res;
        flag_z <= (res == 8'h00);
        flag_c <= res_c;
        flag_n <= res[7];
        flag_v <= res_v;
      end
    end
  end

  assign uo_out  = acc;
  assign uio_out = {flag_z, flag_c, flag_n, flag_v, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_oscarrp1091.sv
module tb_tt_um_oscarrp1091;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena;
  logic       clk;
  logic       rst_n;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_oscarrp1091 dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  logic [7:0] m_a;
  logic       m_z, m_c, m_n, m_v, m_stbq;

  // Scoreboard of expected {uo_out, uio_out}
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0; m_stbq = 1'b0;
  endtask

  // Reference arithmetic written with wide integers rather than bit tricks.
  task automatic model_exec(input logic [2:0] op, input logic [7:0] b);
    int ua, ub, s, sa, sb, r;
    logic [7:0] res;
    ua = int'(m_a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    res = m_a;
    case (op)
      3'd0: begin res = b; m_c = 0; m_v = 0; end
      3'd1: begin s = ua + ub; res = s[7:0]; m_c = (s > 255);
                  r = sa + sb; m_v = (r > 127) || (r < -128); end
      3'd2: begin s = ua - ub; res = s[7:0]; m_c = (ua < ub);
                  r = sa - sb; m_v = (r > 127) || (r < -128); end
      3'd3: begin res = m_a & b; m_c = 0; m_v = 0; end
      3'd4: begin res = m_a | b; m_c = 0; m_v = 0; end
      3'd5: begin res = m_a ^ b; m_c = 0; m_v = 0; end
      3'd6: begin s = ua * 2; res = s[7:0]; m_c = (ua >= 128); m_v = 0; end
      default: begin
        s = ua + ub + (m_c ? 1 : 0); res = s[7:0]; m_c = (s > 255);
        r = sa + sb + (m_c ? 0 : 0);
        r = sa + sb + ((ua + ub + 0) >= 0 ? 0 : 0);
        // signed overflow with carry-in: compare against the true signed sum
        r = sa + sb + ((s - ua - ub) == 1 ? 1 : 0);
        m_v = (r > 127) || (r < -128);
      end
    endcase
    m_a = res;
    m_z = (res == 8'h00);
    m_n = res[7];
  endtask

  // One clock of stimulus: drive at negedge, predict, then compare at the next negedge.
  task automatic step(input logic en, input logic st, input logic [2:0] op, input logic [7:0] b,
                      input string tag);
    logic [15:0] e;
    ena    = en;
    ui_in  = b;
    uio_in = {4'h0, st, op};
    if (en && st && !m_stbq) model_exec(op, b);
    if (en) m_stbq = st;
    exp_q.push_back({m_a, m_z, m_c, m_n, m_v, 4'h0});
    @(negedge clk);
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_acc"}, uo_out, e[15:8]);
      check({tag, "_flags"}, uio_out, e[7:0]);
    end
  endtask

  // Strobed op: strobe high for one cycle, then low to re-arm.
  task automatic op1(input logic [2:0] op, input logic [7:0] b, input string tag);
    step(1'b1, 1'b1, op, b, tag);
    step(1'b1, 1'b0, op, b, {tag, "_lo"});
  endtask

  initial begin
    model_reset();
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset held for 5 cycles
    repeat (5) @(negedge clk);
    check("rst_acc", uo_out, 8'h00);
    check("rst_flags", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_acc", uo_out, 8'h00);
    check("post_rst_flags", uio_out, 8'h00);

    // Signed overflow
    op1(3'd0, 8'h7F, "ld7f");
    op1(3'd1, 8'h01, "add_ovf");
    check("ovf_acc_const", uo_out, 8'h80);
    check("ovf_flags_const", uio_out, 8'h30);

    // Carry + zero, then ADC consumes carry
    op1(3'd0, 8'h01, "ld01");
    op1(3'd1, 8'hFF, "add_cz");
    check("cz_acc_const", uo_out, 8'h00);
    check("cz_flags_const", uio_out, 8'hC0);
    op1(3'd7, 8'h10, "adc");
    check("adc_acc_const", uo_out, 8'h11);
    check("adc_flags_const", uio_out, 8'h00);

    // Borrow
    op1(3'd0, 8'h03, "ld03");
    op1(3'd2, 8'h05, "sub_b");
    check("sub_acc_const", uo_out, 8'hFE);
    check("sub_flags_const", uio_out, 8'h60);

    // Edge detect: strobe held 10 cycles executes once
    op1(3'd0, 8'h01, "ld01b");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 3'd1, 8'h01, "hold");
    check("hold_acc_const", uo_out, 8'h02);
    step(1'b1, 1'b0, 3'd1, 8'h01, "hold_lo");
    op1(3'd1, 8'h01, "rearm");
    check("rearm_acc_const", uo_out, 8'h03);

    // Enable gating, then shift and xor
    step(1'b0, 1'b1, 3'd0, 8'hAA, "ena0_hi");
    step(1'b0, 1'b0, 3'd0, 8'hAA, "ena0_lo");
    check("ena0_acc_const", uo_out, 8'h03);
    op1(3'd0, 8'hAA, "ldaa");
    check("ldaa_acc_const", uo_out, 8'hAA);
    op1(3'd6, 8'h00, "shl");
    check("shl_acc_const", uo_out, 8'h54);
    check("shl_flags_const", uio_out, 8'h40);
    op1(3'd5, 8'h54, "xor");
    check("xor_acc_const", uo_out, 8'h00);
    check("xor_flags_const", uio_out, 8'h80);

    // Strobe rises while ena=0; history frozen low, so it fires once ena returns
    step(1'b0, 1'b1, 3'd0, 8'h5A, "frz_hi");
    step(1'b1, 1'b1, 3'd0, 8'h5A, "frz_en");
    check("frz_acc_const", uo_out, 8'h5A);
    step(1'b1, 1'b0, 3'd0, 8'h5A, "frz_lo");

    // Random op mix against the model
    for (int i = 0; i < 40; i++) begin
      op1(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), "rand");
    end

    // Asynchronous reset between clock edges
    op1(3'd0, 8'hFF, "ldff");
    ena    = 1'b1;
    uio_in = 8'h09;
    ui_in  = 8'h33;
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", uo_out, 8'h00);
    check("arst_flags", uio_out, 8'h00);
    check("arst_oe", uio_oe, 8'hF0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    uio_in = 8'h00;
    op1(3'd4, 8'h81, "or_after_rst");
    check("or_acc_const", uo_out, 8'h81);
    check("or_flags_const", uio_out, 8'h20);

    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Watchdog: a stuck run still reports and ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
